// File: rtl/ps2_keycode_rx_if.sv
// PS/2 line and key-event bundle between the keyboard pins and the receiver.
// The receiver uses the slave modport and the line driver the master modport.
interface ps2_keycode_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] keyCode;
    logic        key_valid;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyCode,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyCode,
        output key_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver folding E0/F0 prefixes into 32-bit key events.
// Define PS2_RX_PARITY_CHECK_EN to reject frames that fail odd parity.
module ps2_keycode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 130000
) (
    input  logic             clk,
    input  logic             rst,
    ps2_keycode_rx_if.slave  bus
);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic             flt_level_q, strobe_q;
    logic [FLT_W-1:0] flt_cnt_q;
    state_e           state_q, state_d;
    logic [7:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             ext_q, brk_q;
    logic [31:0]      key_code_q;
    logic             key_valid_q, frame_err_q;
    logic             timeout_hit_c, shift_en_c, stop_c, parity_ok_c;
    logic             byte_ok_c, err_c, prefix_clr_c;

    // Synchronizers and saturating clock filter; strobe marks a filtered fall
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            flt_level_q <= 1'b1;
            flt_cnt_q   <= '0;
            strobe_q    <= 1'b0;
        end else begin
            clk_meta_q  <= bus.ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= bus.ps2_data;
            data_sync_q <= data_meta_q;
            strobe_q    <= 1'b0;
            if (clk_sync_q != flt_level_q) begin
                if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                    flt_level_q <= clk_sync_q;
                    flt_cnt_q   <= '0;
                    strobe_q    <= flt_level_q;
                end else begin
                    flt_cnt_q <= flt_cnt_q + FLT_W'(1);
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        timeout_hit_c = (state_q != S_IDLE) && !strobe_q &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        case (state_q)
            S_IDLE:   if (strobe_q && !data_sync_q) state_d = S_DATA;
            S_DATA:   if (strobe_q && bit_cnt_q == 4'd7) state_d = S_PARITY;
            S_PARITY: if (strobe_q) state_d = S_STOP;
            S_STOP:   if (strobe_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (timeout_hit_c) state_d = S_IDLE;
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst)                                 parity_q <= 1'b0;
        else if (strobe_q && state_q == S_PARITY) parity_q <= data_sync_q;
    end

    assign parity_ok_c = ^{shift_q, parity_q};
`else
    assign parity_ok_c = 1'b1;
`endif

    always_comb begin
        shift_en_c   = strobe_q && (state_q == S_DATA);
        stop_c       = strobe_q && (state_q == S_STOP);
        byte_ok_c    = stop_c && data_sync_q && parity_ok_c;
        err_c        = stop_c && !(data_sync_q && parity_ok_c);
        prefix_clr_c = stop_c && !parity_ok_c;
    end

    // Deserializer datapath, timeout counter and byte assembler
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= err_c;
            to_cnt_q    <= (state_q == S_IDLE || strobe_q) ? '0 : to_cnt_q + TO_W'(1);
            if (state_q == S_IDLE) bit_cnt_q <= '0;
            if (shift_en_c) begin
                shift_q   <= {data_sync_q, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (byte_ok_c) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    key_code_q  <= {(brk_q ? 16'h00F0 : 16'h0000), (ext_q ? 8'hE0 : 8'h00), shift_q};
                    key_valid_q <= 1'b1;
                    ext_q       <= 1'b0;
                    brk_q       <= 1'b0;
                end
            end
            if (prefix_clr_c) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    assign bus.keyCode   = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: frames driven bit by bit on the PS/2 lines.
// Timeout threshold is shortened so the stall case stays brief.
module tb_ps2_keycode_rx;
    localparam int unsigned TO_CYC = 2000;
    localparam int          HALF   = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0, fails = 0;
    int   kv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int   k0, f0;

    always #5 clk = ~clk;

    ps2_keycode_rx_if bus();

    ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.key_valid) kv_cnt++;
        if (bus.frame_err) fe_cnt++;
        if (bus.key_valid && bus.frame_err) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        tick(HALF / 2);
        bus.ps2_clk = 1'b0;
        tick(HALF);
        bus.ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d ^ par_flip);
        send_bit(stop);
        tick(20);
    endtask

    task automatic mark;
        k0 = kv_cnt;
        f0 = fe_cnt;
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);
        check("reset_keycode", bus.keyCode, 32'h0);
        check("reset_valid", 32'(bus.key_valid), 32'h0);
        check("reset_err", 32'(bus.frame_err), 32'h0);
        rst = 1'b1;
        tick(5);

        mark();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("make_a", bus.keyCode, 32'h0000001C);
        check("make_a_pulses", 32'(kv_cnt - k0), 32'd1);
        check("make_a_noerr", 32'(fe_cnt - f0), 32'd0);
        tick(200);
        check("make_a_held", bus.keyCode, 32'h0000001C);

        mark();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("break_a", bus.keyCode, 32'h00F0001C);
        check("break_a_pulses", 32'(kv_cnt - k0), 32'd1);

        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("ext_make", bus.keyCode, 32'h0000E075);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("ext_break", bus.keyCode, 32'h00F0E075);

        send_frame(8'h23, 1'b0, 1'b1);
        mark();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("parity_keycode", bus.keyCode, 32'h00000023);
        check("parity_err", 32'(fe_cnt - f0), 32'd1);
        check("parity_valid", 32'(kv_cnt - k0), 32'd0);
`else
        check("parity_keycode", bus.keyCode, 32'h00F0001C);
        check("parity_err", 32'(fe_cnt - f0), 32'd0);
        check("parity_valid", 32'(kv_cnt - k0), 32'd1);
`endif
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after_parity", bus.keyCode, 32'h0000001C);

        mark();
        send_frame(8'h29, 1'b0, 1'b0);
        check("bad_stop_err", 32'(fe_cnt - f0), 32'd1);
        check("bad_stop_valid", 32'(kv_cnt - k0), 32'd0);
        check("bad_stop_keycode", bus.keyCode, 32'h0000001C);

        send_frame(8'h29, 1'b0, 1'b1);
        check("space", bus.keyCode, 32'h00000029);
        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(TO_CYC + 100);
        check("timeout_valid", 32'(kv_cnt - k0), 32'd0);
        check("timeout_err", 32'(fe_cnt - f0), 32'd0);
        check("timeout_keycode", bus.keyCode, 32'h00000029);
        send_frame(8'h23, 1'b0, 1'b1);
        check("after_timeout", bus.keyCode, 32'h00000023);

        mark();
        bus.ps2_data = 1'b0;
        tick(5);
        bus.ps2_clk = 1'b0;
        tick(4);
        bus.ps2_clk = 1'b1;
        tick(50);
        bus.ps2_data = 1'b1;
        send_frame(8'h1D, 1'b0, 1'b1);
        check("glitch_keycode", bus.keyCode, 32'h0000001D);
        check("glitch_pulses", 32'(kv_cnt - k0), 32'd1);
        check("glitch_noerr", 32'(fe_cnt - f0), 32'd0);

        send_frame(8'hF0, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        tick(1);
        check("midrst_keycode", bus.keyCode, 32'h0);
        check("midrst_valid", 32'(bus.key_valid), 32'h0);
        check("midrst_err", 32'(bus.frame_err), 32'h0);
        rst = 1'b1;
        tick(20);
        mark();
        send_frame(8'h1B, 1'b0, 1'b1);
        check("after_rst", bus.keyCode, 32'h0000001B);

        send_frame(8'h1B, 1'b0, 1'b1);
        check("typematic_keycode", bus.keyCode, 32'h0000001B);
        check("typematic_pulses", 32'(kv_cnt - k0), 32'd2);
        check("no_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

PS/2 keyboard receiver that sits directly upstream of the key decoder. Samples the raw `ps2_clk`/`ps2_data` lines, deserializes 11-bit device-to-host frames and folds the `E0` (extended) and `F0` (break) prefix bytes into one 32-bit key event. Presents that event on `keyCode` in the `keyboardPkg` layout: `[15:0]` is the scancode, `[31:16]` is `RELEASED` or zero.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronized samples required before a `ps2_clk` level change is accepted.
- `TIMEOUT_CYCLES`, 130000: idle `clk` cycles mid-frame before the deserializer aborts (2 ms at 65 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst == 0` resets).
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous.
- `keyCode`  out  32  last complete key event; held until the next event.
- `key_valid`  out  1  one-cycle pulse when `keyCode` is updated.
- `frame_err`  out  1  one-cycle pulse on a rejected frame.

## Operation
- Both lines pass through a 2-FF synchronizer.
- `ps2_clk` then passes a saturating filter: the filtered level flips only after `FILTER_LEN` equal samples.
- A falling edge of the filtered clock is the sample strobe; `ps2_data` is taken from the synchronizer at that strobe.
- Frame FSM:
  - IDLE: strobe with data 0 → DATA, bit count 0. Strobe with data 1 is ignored.
  - DATA: shift data LSB-first; after 8 bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: stop bit 1 → byte accepted; stop bit 0 → `frame_err`, byte dropped. Either way → IDLE.
- Timeout: in any state other than IDLE, a counter runs and clears on every strobe. Reaching `TIMEOUT_CYCLES` → IDLE silently, with no `frame_err`. Prefix flags are kept.
- Byte assembler, acting on each accepted byte:
  - `E0`: set `ext`.
  - `F0`: set `brk`.
  - Any other byte: `keyCode <= {brk ? 16'h00F0 : 16'h0000, ext ? 8'hE0 : 8'h00, byte}`, pulse `key_valid`, clear `ext` and `brk`.
- Typematic repeats (the same make code again) update `keyCode` to the same value and still pulse `key_valid`.
- Codes match `keyboardPkg`: A `16'h001C`, D `16'h0023`, W `16'h001D`, S `16'h001B`, SPACE `16'h0029`, ENTER `16'h005A`, RELEASED `16'h00F0`.

## Timing
- Reset values: `keyCode = 32'h0`, `key_valid = 0`, `frame_err = 0`, FSM = IDLE, `ext = brk = 0`, filter level = 1, timeout counter = 0.
- Reset applied mid-frame or mid-sequence discards all partial state on the next `clk` edge.
- Edge latency: a raw `ps2_clk` fall produces the strobe 2 + `FILTER_LEN` cycles later.
- Update latency: `keyCode` and `key_valid` update on the first `clk` edge after the strobe that samples the stop bit.
- `key_valid` and `frame_err` never assert in the same cycle. Each is high for exactly one cycle per frame.
- Strobe and timeout in the same cycle: the strobe wins and the counter clears.
- Bit counter is 4 bits and never wraps past 8 within DATA.
- No backpressure. The consumer samples `keyCode` every cycle; frames arrive at least ~600 µs apart.

## Configuration
- `PS2_RX_PARITY_CHECK_EN` defined:
  - Odd parity over data and parity bit is checked in STOP.
  - Mismatch → `frame_err`, byte dropped, `ext` and `brk` cleared.
- Not defined:
  - Parity bit is captured but ignored.
  - Only a bad stop bit raises `frame_err`.

## Test plan
- Make A: frame `1C` (parity 0, stop 1) → `keyCode = 32'h0000001C`, one `key_valid` pulse; value held afterwards.
- Break A: frames `F0`, `1C` → exactly one `key_valid`, `keyCode = 32'h00F0001C`.
- Extended: `E0 75` → `32'h0000E075`; then `E0 F0 75` → `32'h00F0E075`.
- Parity error, macro on: frame `1C` with parity 1 → `frame_err` pulse, `keyCode` unchanged. Macro off: same frame → `keyCode = 32'h0000001C`.
- Timeout: start bit plus 4 data bits, then stall 130000 cycles → no outputs. A following frame `23` → `keyCode = 32'h00000023`.
- Reset and glitch: `rst = 0` for one cycle during DATA → all outputs zero, FSM in IDLE. A `ps2_clk` glitch shorter than `FILTER_LEN` cycles produces no strobe.
